// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register; owns the PC and a synchronous imem.
// A one-entry hold buffer keeps the in-flight response alive across stalls.
module fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP      = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } slot_t;

  localparam slot_t BUBBLE = '{valid: 1'b0, pc: '0, instr: NOP};

  logic [XLEN-1:0] pc;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;
  slot_t           hold;
  slot_t           if_id;
  slot_t           fetched;
  slot_t           next_if_id;

  assign imem_req  = !rst && !flush && !stall;
  assign imem_addr = pc;

  assign fetched = '{valid: 1'b1, pc: inflight_pc, instr: imem_rdata};

  // Buffered word is always older than anything in flight.
  always_comb begin
    next_if_id = BUBBLE;
    unique case (1'b1)
      hold.valid: next_if_id = hold;
      inflight:   next_if_id = fetched;
      default:    next_if_id = BUBBLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      hold        <= BUBBLE;
      if_id       <= BUBBLE;
    end else if (flush) begin
      pc          <= branch_target;
      inflight    <= 1'b0;
      hold.valid  <= 1'b0;
      if_id       <= BUBBLE;
    end else if (stall) begin
      if (inflight) begin
        hold     <= fetched;
        inflight <= 1'b0;
      end
    end else begin
      if_id       <= next_if_id;
      hold.valid  <= 1'b0;
      inflight    <= 1'b1;
      inflight_pc <= pc;
      pc          <= pc + XLEN'(4);
    end
  end

  assign if_id_valid = if_id.valid;
  assign if_id_pc    = if_id.pc;
  assign if_id_instr = if_id.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed plan plus random rst/flush/stall traffic
// against a queue-based model of the fetched instruction stream.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] branch_target = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  int checks = 0;
  int errors = 0;
  logic [31:0] key = '0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .branch_target(branch_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .if_id_valid(if_id_valid),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ key;
  endfunction

  // Synchronous memory; garbage on idle cycles so stale data is visible.
  always @(posedge clk)
    imem_rdata <= imem_req ? mem_word(imem_addr) : $urandom;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_npc = '0;
  logic        m_req = 1'b0;
  ent_t        m_last;
  logic        e_valid = 1'b0;
  logic [31:0] e_pc = '0;
  logic [31:0] e_instr = NOP;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bubble();
    e_valid = 1'b0;
    e_pc    = '0;
    e_instr = NOP;
  endtask

  // Fetch stream model: every issued request yields one entry, delivered in
  // order on non-stalled edges; rst/flush drop everything not yet delivered.
  task automatic model_edge();
    ent_t e;
    if (rst) begin
      q.delete();
      bubble();
      m_npc = '0;
      m_req = 1'b0;
    end else if (flush) begin
      q.delete();
      bubble();
      m_npc = branch_target;
      m_req = 1'b0;
    end else if (stall) begin
      if (m_req) q.push_back(m_last);
      m_req = 1'b0;
    end else begin
      if (m_req) q.push_back(m_last);
      if (q.size() > 0) begin
        e       = q.pop_front();
        e_valid = 1'b1;
        e_pc    = e.pc;
        e_instr = e.instr;
      end else begin
        bubble();
      end
      m_last.pc    = m_npc;
      m_last.instr = mem_word(m_npc);
      m_req        = 1'b1;
      m_npc        = m_npc + 32'd4;
    end
  endtask

  task automatic cyc(input logic r, input logic f, input logic s,
                     input logic [31:0] t);
    logic exp_req;
    rst = r; flush = f; stall = s; branch_target = t;
    #1;
    exp_req = !r && !f && !s;
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_npc);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, e_valid});
    chk("if_id_pc", if_id_pc, e_pc);
    chk("if_id_instr", if_id_instr, e_instr);
  endtask

  task automatic lit(input string name, input logic v,
                     input logic [31:0] p, input logic [31:0] i);
    chk({name, "_valid"}, {31'b0, if_id_valid}, {31'b0, v});
    chk({name, "_pc"}, if_id_pc, p);
    chk({name, "_instr"}, if_id_instr, i);
  endtask

  initial begin
    int rr, fr, sr;
    logic [31:0] tg;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    lit("reset", 0, 0, NOP);
    cyc(0, 0, 0, 0);
    lit("first_edge", 0, 0, NOP);
    cyc(0, 0, 0, 0);
    lit("pc0", 1, 32'h0, 32'h0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    lit("pc8", 1, 32'h8, 32'h8);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0);
      lit("stall_hold", 1, 32'h8, 32'h8);
    end
    cyc(0, 0, 0, 0);
    lit("after_stall", 1, 32'hc, 32'hc);
    cyc(0, 0, 0, 0);
    lit("pc10", 1, 32'h10, 32'h10);
    cyc(0, 1, 0, 32'h100);
    lit("flush_b1", 0, 0, NOP);
    cyc(0, 0, 0, 0);
    lit("flush_b2", 0, 0, NOP);
    cyc(0, 0, 0, 0);
    lit("target", 1, 32'h100, 32'h100);
    cyc(0, 0, 0, 0);
    lit("target4", 1, 32'h104, 32'h104);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 32'h200);
    lit("fs_b1", 0, 0, NOP);
    cyc(0, 0, 0, 0);
    lit("fs_b2", 0, 0, NOP);
    cyc(0, 0, 0, 0);
    lit("fs_target", 1, 32'h200, 32'h200);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 0);
    lit("rst_stall", 0, 0, NOP);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    lit("restart", 1, 32'h0, 32'h0);
    cyc(0, 1, 0, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    lit("wrap_hi", 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    lit("wrap_lo", 1, 32'h0, 32'h0);

    key = $urandom;
    for (int n = 0; n < 3000; n++) begin
      rr = $urandom_range(0, 99);
      fr = $urandom_range(0, 99);
      sr = $urandom_range(0, 99);
      tg = $urandom;
      if ($urandom_range(0, 3) != 0) tg[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) tg = 32'hFFFF_FFF8;
      cyc(rr < 2, fr < 10, sr < 25, tg);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage with integrated IF/ID pipeline register. It sits directly upstream of the pipeline flush logic and consumes its `flush` output, together with the branch target resolved in EX. It owns the PC, drives a synchronous instruction memory with 1-cycle read latency, and presents instructions to decode. It honours load-use `stall` from the hazard unit without losing the in-flight memory response.

## Interface
- `XLEN`, 32, address/PC width.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `NOP`, 32'h0000_0013, instruction word inserted on bubbles (`addi x0,x0,0`).

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `flush`  in  1  taken branch/jump redirect from pipeline flush logic.
- `branch_target`  in  XLEN  redirect PC; sampled only when `flush`=1.
- `stall`  in  1  hazard-unit freeze of IF and IF/ID.
- `imem_req`  out  1  read request this cycle.
- `imem_addr`  out  XLEN  read address; equals `pc`.
- `imem_rdata`  in  32  read data; valid the cycle after a request.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `if_id_pc`  out  XLEN  PC of the IF/ID instruction.
- `if_id_instr`  out  32  IF/ID instruction word (`NOP` when invalid).

## Operation
- Internal state:
  - `pc`;
  - `inflight` + `inflight_pc`, meaning a request was issued last cycle and `imem_rdata` is its response this cycle;
  - one-entry hold buffer `buf_valid`/`buf_instr`/`buf_pc`.
- Invariant: `inflight` and `buf_valid` are never both 1.
- `imem_req` = !rst && !flush && !stall. `imem_addr` = `pc` (combinational).
- Per-edge priority: rst > flush > stall > normal.
- rst:
  - `pc`<=RESET_PC; `inflight`<=0; `buf_valid`<=0.
  - `if_id_valid`<=0, `if_id_instr`<=NOP, `if_id_pc`<=0.
- flush (overrides stall):
  - `pc`<=branch_target.
  - Current `imem_rdata` is discarded: `inflight`<=0, `buf_valid`<=0.
  - IF/ID <= bubble (valid 0, NOP, pc 0).
- stall, no flush:
  - `pc` and IF/ID hold.
  - If `inflight`: `buf_instr`<=imem_rdata, `buf_pc`<=inflight_pc, `buf_valid`<=1, `inflight`<=0.
- normal:
  - If `buf_valid`: IF/ID <= buffer, then `buf_valid`<=0.
  - Else if `inflight`: IF/ID <= {1, inflight_pc, imem_rdata}.
  - Else: IF/ID <= bubble.
  - Request issued: `inflight`<=1, `inflight_pc`<=pc, `pc`<=pc+4.
- PC arithmetic is modulo 2^XLEN: 0xFFFF_FFFC+4 wraps to 0.
- `branch_target` is used as given; no alignment check.

## Timing
- Reset values: `if_id_valid`=0, `if_id_instr`=NOP, `if_id_pc`=0. `imem_req`=0 while `rst`=1.
- Reset release:
  - First cycle with `rst`=0 requests RESET_PC.
  - IF/ID shows RESET_PC (valid) after the following edge, i.e. fetch latency = 2 edges.
- Steady state: one instruction per cycle; consecutive IF/ID PCs differ by 4.
- Flush asserted in cycle t:
  - Edge ending t: IF/ID bubble.
  - Cycle t+1: request `branch_target`.
  - Edge ending t+1: IF/ID bubble.
  - Edge ending t+2: IF/ID = target instruction.
  - Branch penalty in IF/ID: 2 bubbles.
- Stall of N cycles:
  - IF/ID holds N edges; no request is issued.
  - The response in flight at stall onset is buffered.
  - First edge after stall drops: buffer → IF/ID. No instruction is lost or duplicated.
- Stall and flush in the same cycle: flush behaviour; the buffer is cleared.
- `rst` mid-stall or mid-flush: reset behaviour; buffer and in-flight contents are dropped.

## Test plan
- Reset, then run with memory word = address: IF/ID sequence (pc,instr) = (0,0),(4,4),(8,8)…, valid from the 2nd edge after release.
- Stall for 3 cycles after IF/ID shows pc 8: IF/ID holds 8 for 3 edges, `imem_req`=0, then 12,16,… with no gap or repeat.
- Flush with target 0x100 while IF/ID=0x10: two bubbles (valid 0, instr 0x13), then 0x100, 0x104; response for 0x14 never appears.
- Flush and stall in the same cycle with target 0x200: identical to a plain flush; the held instruction is discarded; next valid pc=0x200.
- `rst` asserted during stall with buffer full: all outputs take reset values next edge; after release, fetch restarts at RESET_PC.
- Flush target 0xFFFF_FFFC: IF/ID pcs 0xFFFF_FFFC then 0x0000_0000.
